// File: rtl/bram_rr_arbiter_if.sv
// Command/response bundle between NREQ client engines, the arbiter and a single-cycle BRAM.
// Per-requester fields are flattened: requester i sits at [i*W +: W].
interface bram_rr_arbiter_if #(
    parameter int NREQ = 2,
    parameter int ALEN = 8,
    parameter int DLEN = 32
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_we;
    logic [NREQ*ALEN-1:0] req_addr;
    logic [NREQ*DLEN-1:0] req_wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [DLEN-1:0]      rsp_data;
    logic                 mem_wen;
    logic [ALEN-1:0]      mem_waddr;
    logic [DLEN-1:0]      mem_wdata;
    logic                 mem_ren;
    logic [ALEN-1:0]      mem_raddr;
    logic                 mem_rvalid;
    logic [DLEN-1:0]      mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_data,
               mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_data,
               mem_wen, mem_waddr, mem_wdata, mem_ren, mem_raddr
    );
endinterface

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter in front of one BRAM: command issued 1 cycle after accept, read data 2 cycles after.
// Backpressure: at most one req_ready per cycle (the grant); responses cannot be stalled.
module bram_rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ALEN = 8,
    parameter int DLEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    bram_rr_arbiter_if.slave   bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   gnt_idx, cand_idx;
    logic            gnt_found, accept;
    logic [NREQ-1:0] grant, rsp_valid;
    int              cand;

    logic            sel_we;
    logic [ALEN-1:0] sel_addr;
    logic [DLEN-1:0] sel_wdata;

    logic            mem_wen_q, mem_wen_d, mem_ren_q, mem_ren_d;
    logic [ALEN-1:0] mem_waddr_q, mem_waddr_d, mem_raddr_q, mem_raddr_d;
    logic [DLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [PW-1:0]   rd_id_q, rd_id_d, pend_id_q, pend_id_d;
    logic            pend_v_q, pend_v_d;

    // Search starts at rr_ptr and wraps modulo NREQ (NREQ need not be a power of two).
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cand_idx = PW'(cand);
            if (!gnt_found && bus.req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
        accept = gnt_found & ~rst;
        grant  = '0;
        if (accept) grant[gnt_idx] = 1'b1;
    end

    assign bus.req_ready = grant;
    assign sel_we    = bus.req_we[gnt_idx];
    assign sel_addr  = bus.req_addr[gnt_idx*ALEN +: ALEN];
    assign sel_wdata = bus.req_wdata[gnt_idx*DLEN +: DLEN];

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        mem_wen_d   = 1'b0;
        mem_ren_d   = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        mem_raddr_d = mem_raddr_q;
        rd_id_d     = rd_id_q;
        // Read tag follows the BRAM's one-cycle latency so it lines up with mem_rvalid.
        pend_v_d    = mem_ren_q;
        pend_id_d   = rd_id_q;
        if (accept) begin
            rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            if (sel_we) begin
                mem_wen_d   = 1'b1;
                mem_waddr_d = sel_addr;
                mem_wdata_d = sel_wdata;
            end else begin
                mem_ren_d   = 1'b1;
                mem_raddr_d = sel_addr;
                rd_id_d     = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            mem_wen_q   <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mem_raddr_q <= '0;
            rd_id_q     <= '0;
            pend_v_q    <= 1'b0;
            pend_id_q   <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            mem_wen_q   <= mem_wen_d;
            mem_ren_q   <= mem_ren_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_raddr_q <= mem_raddr_d;
            rd_id_q     <= rd_id_d;
            pend_v_q    <= pend_v_d;
            pend_id_q   <= pend_id_d;
        end
    end

    // A BRAM rvalid with no matching pending read (e.g. issued before a reset) is dropped.
    always_comb begin
        rsp_valid = '0;
        if (pend_v_q && bus.mem_rvalid && !rst) rsp_valid[pend_id_q] = 1'b1;
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = bus.mem_rdata;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_ren   = mem_ren_q;
    assign bus.mem_waddr = mem_waddr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_raddr = mem_raddr_q;
endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Bench for bram_rr_arbiter with NREQ=4: directed scenarios plus randomized traffic
// checked against a queue-level model of round-robin grant order, memory contents and response timing.
module tb_bram_rr_arbiter;
    localparam int NREQ = 4;
    localparam int ALEN = 8;
    localparam int DLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bram_rr_arbiter_if #(.NREQ(NREQ), .ALEN(ALEN), .DLEN(DLEN)) bus ();
    bram_rr_arbiter #(.NREQ(NREQ), .ALEN(ALEN), .DLEN(DLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DLEN-1:0] bram   [256];
    logic [DLEN-1:0] shadow [256];
    int n_cmp = 0;
    int n_err = 0;

    // Single-cycle BRAM: write commits at the edge, read data + rvalid one edge after ren.
    always @(posedge clk) begin
        if (bus.mem_wen) bram[bus.mem_waddr] <= bus.mem_wdata;
        bus.mem_rvalid <= bus.mem_ren;
        if (bus.mem_ren) bus.mem_rdata <= bram[bus.mem_raddr];
    end

    task automatic clear_req();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic [ALEN-1:0] a, input logic [DLEN-1:0] d);
        bus.req_valid[i]               = 1'b1;
        bus.req_we[i]                  = we;
        bus.req_addr[i*ALEN +: ALEN]   = a;
        bus.req_wdata[i*DLEN +: DLEN]  = d;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_req();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        bus.req_valid = '1;
        bus.req_we    = 4'b0101;
        bus.req_addr  = 32'h11223344;
        bus.req_wdata = '1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
            n_cmp++; if ({bus.mem_wen, bus.mem_ren} !== 2'b00) begin n_err++; $display("FAIL rst_en: got wen=%b ren=%b want 0/0", bus.mem_wen, bus.mem_ren); end
            n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rst_rsp: got %b want 0000", bus.rsp_valid); end
        end
        n_cmp++; if ({bus.mem_waddr, bus.mem_raddr, bus.mem_wdata} !== '0) begin n_err++; $display("FAIL rst_bus: got waddr=%h raddr=%h wdata=%h want 0", bus.mem_waddr, bus.mem_raddr, bus.mem_wdata); end
        @(posedge clk); #1;
        clear_req();
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        do_reset();
        set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
        shadow[8'h10] = 32'hDEADBEEF;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL wr_grant: got %b want 0001", bus.req_ready); end
        @(posedge clk); #1;
        clear_req();
        set_req(0, 1'b0, 8'h10, '0);
        @(negedge clk);
        n_cmp++; if ({bus.mem_wen, bus.mem_ren} !== 2'b10) begin n_err++; $display("FAIL wr_issue: got wen=%b ren=%b want 1/0", bus.mem_wen, bus.mem_ren); end
        n_cmp++; if ({bus.mem_waddr, bus.mem_wdata} !== {8'h10, 32'hDEADBEEF}) begin n_err++; $display("FAIL wr_fields: got %h/%h want 10/deadbeef", bus.mem_waddr, bus.mem_wdata); end
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL rd_grant: got %b want 0001", bus.req_ready); end
        @(posedge clk); #1;
        clear_req();
        @(negedge clk);
        n_cmp++; if ({bus.mem_wen, bus.mem_ren, bus.mem_raddr} !== {2'b01, 8'h10}) begin n_err++; $display("FAIL rd_issue: got wen=%b ren=%b raddr=%h want 0/1/10", bus.mem_wen, bus.mem_ren, bus.mem_raddr); end
        n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rd_early: got %b want 0000", bus.rsp_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 4'b0001) begin n_err++; $display("FAIL rd_rsp_v: got %b want 0001", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rsp_d: got %h want deadbeef", bus.rsp_data); end
    endtask

    task automatic test_alternate();
        logic [NREQ-1:0] exp_v;
        do_reset();
        set_req(0, 1'b0, 8'h01, '0);
        set_req(1, 1'b0, 8'h02, '0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_v = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            if (k < 4) begin
                n_cmp++; if (bus.req_ready !== exp_v) begin n_err++; $display("FAIL alt_grant%0d: got %b want %b", k, bus.req_ready, exp_v); end
            end
            if (k >= 2) begin
                n_cmp++; if (bus.rsp_valid !== exp_v) begin n_err++; $display("FAIL alt_rsp%0d: got %b want %b", k, bus.rsp_valid, exp_v); end
                n_cmp++; if (bus.rsp_data !== shadow[(k % 2 == 0) ? 1 : 2]) begin n_err++; $display("FAIL alt_data%0d: got %h want %h", k, bus.rsp_data, shadow[(k % 2 == 0) ? 1 : 2]); end
            end
            @(posedge clk); #1;
            if (k == 3) clear_req();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        set_req(3, 1'b0, 8'h33, '0);
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_g3: got %b want 1000", bus.req_ready); end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 8'(i), '0);
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_g0: got %b want 0001", bus.req_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL wrap_g1: got %b want 0010", bus.req_ready); end
        @(posedge clk); #1;
        clear_req();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_req(1, 1'b0, 8'h05, '0);
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_grant: got %b want 0010", bus.req_ready); end
        @(posedge clk); #1;
        clear_req();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (bus.mem_ren !== 1'b0) begin n_err++; $display("FAIL mid_ren: got %b want 0", bus.mem_ren); end
        #1 rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL mid_rsp%0d: got %b want 0000", c, bus.rsp_valid); end
        end
        @(posedge clk); #1;
        set_req(1, 1'b0, 8'h01, '0);
        set_req(3, 1'b0, 8'h03, '0);
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_ptr: got %b want 0010", bus.req_ready); end
        @(posedge clk); #1;
        clear_req();
        // Reset after the BRAM has already latched the read: its rvalid must be ignored.
        @(posedge clk); #1;
        rst = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 4'b0000) begin n_err++; $display("FAIL stale_rsp: got %b want 0000", bus.rsp_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(1, 1'b1, 8'h20, 32'h5);
        shadow[8'h20] = 32'h5;
        @(posedge clk); #1;
        clear_req();
        set_req(0, 1'b0, 8'h20, '0);
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL b2b_grant: got %b want 0001", bus.req_ready); end
        @(posedge clk); #1;
        clear_req();
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 4'b0001) begin n_err++; $display("FAIL b2b_rsp_v: got %b want 0001", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== 32'h5) begin n_err++; $display("FAIL b2b_rsp_d: got %h want 5", bus.rsp_data); end
    endtask

    task automatic test_random();
        bit              pv  [NREQ];
        logic            pwe [NREQ];
        logic [ALEN-1:0] pa  [NREQ];
        logic [DLEN-1:0] pd  [NREQ];
        int              ptr, g, r1id, r2id;
        logic            iss_w, iss_r, r1v, r2v;
        logic [ALEN-1:0] iss_a;
        logic [DLEN-1:0] iss_d, r1d, r2d;
        logic [NREQ-1:0] exp_rdy, exp_rv;
        do_reset();
        ptr = 0; iss_w = 0; iss_r = 0; iss_a = '0; iss_d = '0;
        r1v = 0; r2v = 0; r1id = 0; r2id = 0; r1d = '0; r2d = '0;
        for (int i = 0; i < NREQ; i++) begin pv[i] = 0; pwe[i] = 0; pa[i] = '0; pd[i] = '0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 99) < 55) begin
                    pv[i]  = 1;
                    pwe[i] = 1'($urandom_range(0, 1));
                    pa[i]  = 8'($urandom_range(0, 15));
                    pd[i]  = $urandom;
                end
            end
            clear_req();
            for (int i = 0; i < NREQ; i++) if (pv[i]) set_req(i, pwe[i], pa[i], pd[i]);
            @(negedge clk);
            g = -1;
            for (int k = 0; k < NREQ; k++) if (g < 0 && pv[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
            exp_rdy = '0;
            if (g >= 0) exp_rdy[g] = 1'b1;
            exp_rv = '0;
            if (r2v) exp_rv[r2id] = 1'b1;
            n_cmp++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_grant@%0d: got %b want %b", cyc, bus.req_ready, exp_rdy); end
            n_cmp++; if ({bus.mem_wen, bus.mem_ren} !== {iss_w, iss_r}) begin n_err++; $display("FAIL rnd_en@%0d: got %b%b want %b%b", cyc, bus.mem_wen, bus.mem_ren, iss_w, iss_r); end
            if (iss_w) begin
                n_cmp++; if ({bus.mem_waddr, bus.mem_wdata} !== {iss_a, iss_d}) begin n_err++; $display("FAIL rnd_wr@%0d: got %h/%h want %h/%h", cyc, bus.mem_waddr, bus.mem_wdata, iss_a, iss_d); end
            end
            if (iss_r) begin
                n_cmp++; if (bus.mem_raddr !== iss_a) begin n_err++; $display("FAIL rnd_raddr@%0d: got %h want %h", cyc, bus.mem_raddr, iss_a); end
            end
            n_cmp++; if (bus.rsp_valid !== exp_rv) begin n_err++; $display("FAIL rnd_rsp@%0d: got %b want %b", cyc, bus.rsp_valid, exp_rv); end
            if (r2v) begin
                n_cmp++; if (bus.rsp_data !== r2d) begin n_err++; $display("FAIL rnd_data@%0d: got %h want %h", cyc, bus.rsp_data, r2d); end
            end
            r2v = r1v; r2id = r1id; r2d = r1d;
            r1v = 0; iss_w = 0; iss_r = 0;
            if (g >= 0) begin
                ptr   = (g + 1) % NREQ;
                iss_a = pa[g];
                if (pwe[g]) begin
                    shadow[pa[g]] = pd[g];
                    iss_w = 1; iss_d = pd[g];
                end else begin
                    iss_r = 1; r1v = 1; r1id = g; r1d = shadow[pa[g]];
                end
                pv[g] = 0;
            end
            @(posedge clk); #1;
        end
        clear_req();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            bram[a]   = 32'hC0DE0000 + 32'(a * 7);
            shadow[a] = 32'hC0DE0000 + 32'(a * 7);
        end
        clear_req();
        test_reset();
        test_write_read();
        test_alternate();
        test_wrap();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
